// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// RV32I fetch stage: issues one imem request per PC, registers the returned word
// for decode, and handles stall, redirect flush, misalignment and response timeout.
module ifetch_unit #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc_in,
    input  logic                stall,
    input  logic                flush,
    ifetch_unit_if.master       imem,
    output logic [31:0]         instr_out,
    output logic [31:0]         instr_pc_out,
    output logic                instr_valid,
    output logic                pc_advance,
    output logic                fetch_busy,
    output logic                fetch_err,
    output logic                misalign_err
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;

    state_t      state, state_n;
    logic [31:0] req_pc, req_pc_n;
    logic [CW-1:0] cnt, cnt_n;
    logic        discard, discard_n;
    logic        req_n, adv_n, iv_n, ferr_n, merr_n;
    logic [31:0] addr_n, instr_n, ipc_n;

    wire fetch_ok = !stall && !flush && !misalign_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_pc        <= '0;
            cnt           <= '0;
            discard       <= 1'b0;
            imem.imem_req <= 1'b0;
            imem.imem_addr <= '0;
            instr_out     <= NOP_INSTR;
            instr_pc_out  <= '0;
            instr_valid   <= 1'b0;
            pc_advance    <= 1'b0;
            fetch_busy    <= 1'b0;
            fetch_err     <= 1'b0;
            misalign_err  <= 1'b0;
        end else begin
            state         <= state_n;
            req_pc        <= req_pc_n;
            cnt           <= cnt_n;
            discard       <= discard_n;
            imem.imem_req <= req_n;
            imem.imem_addr <= addr_n;
            instr_out     <= instr_n;
            instr_pc_out  <= ipc_n;
            instr_valid   <= iv_n;
            pc_advance    <= adv_n;
            fetch_busy    <= (state_n != IDLE);
            fetch_err     <= ferr_n;
            misalign_err  <= merr_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (fetch_ok && pc_in[1:0] == 2'b00) state_n = REQ;
            REQ:   if (flush || imem.imem_ready) state_n = flush ? IDLE : WAIT;
            WAIT: begin
                if (imem.imem_rvalid)  state_n = (discard || flush) ? IDLE : VALID;
                else if (cnt == CNT_LAST) state_n = IDLE;
            end
            VALID: if (flush || !stall) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req_pc_n  = req_pc;
        cnt_n     = cnt;
        discard_n = discard;
        req_n     = imem.imem_req;
        addr_n    = imem.imem_addr;
        instr_n   = instr_out;
        ipc_n     = instr_pc_out;
        iv_n      = instr_valid;
        adv_n     = 1'b0;
        ferr_n    = fetch_err;
        merr_n    = misalign_err && !flush;
        case (state)
            IDLE: begin
                if (fetch_ok) begin
                    if (pc_in[1:0] == 2'b00) begin
                        req_pc_n = pc_in;
                        addr_n   = pc_in;
                        req_n    = 1'b1;
                    end else begin
                        merr_n = 1'b1;
                    end
                end
            end
            REQ: begin
                if (flush) begin
                    req_n = 1'b0;
                end else if (imem.imem_ready) begin
                    req_n = 1'b0;
                    cnt_n = '0;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    discard_n = 1'b0;
                    if (!(discard || flush)) begin
                        instr_n = imem.imem_rdata;
                        ipc_n   = req_pc;
                        iv_n    = 1'b1;
                    end
                end else if (cnt == CNT_LAST) begin
                    ferr_n    = 1'b1;
                    discard_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                    // a redirect mid-wait still has to absorb the late response
                    if (flush) discard_n = 1'b1;
                end
            end
            VALID: begin
                if (flush) begin
                    iv_n    = 1'b0;
                    instr_n = NOP_INSTR;
                end else if (!stall) begin
                    adv_n = 1'b1;
                    iv_n  = 1'b0;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage sitting directly downstream of the PC register in the RV32I core. It samples the current PC and issues a request to instruction memory over a req/ready + rvalid handshake. It registers the returned word with its PC for decode and holds it while the core stalls on a pending load. It also handles redirect flushes, misaligned PCs and memory-response timeouts, and returns a one-cycle pc_advance pulse to the PC register.

Parameters:
TIMEOUT_CYCLES, 16, cycles spent in WAIT without imem_rvalid before fetch_err is raised (minimum 2).
NOP_INSTR, 32'h00000013, value driven on instr_out after reset and after a flush.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
pc_in  input  32  current PC from the PC register.
stall  input  1  core stall (pending load without dmem_valid); holds fetch.
flush  input  1  redirect (taken branch, jal, jalr); discards the in-flight fetch.
imem_req  output  1  request valid to instruction memory.
imem_addr  output  32  request address; stable while imem_req=1 and imem_ready=0.
imem_ready  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  response data valid.
imem_rdata  input  32  response instruction word.
instr_out  output  32  fetched instruction to decode.
instr_pc_out  output  32  PC of instr_out.
instr_valid  output  1  instr_out/instr_pc_out are valid.
pc_advance  output  1  one-cycle pulse: PC register may update.
fetch_busy  output  1  high when state is not IDLE.
fetch_err  output  1  sticky: timeout occurred.
misalign_err  output  1  sticky: pc_in[1:0] was nonzero when sampled.

Behaviour:
- Reset (rst=1 at a clock edge) overrides every other input:
  - state=IDLE; imem_req=0, imem_addr=0; instr_out=NOP_INSTR, instr_pc_out=0, instr_valid=0; pc_advance=0.
  - fetch_err=0, misalign_err=0; timeout counter=0; discard flag=0.
  - Reset asserted mid-transaction abandons it; any later rvalid for that transaction is ignored because the state is IDLE.
- States: IDLE, REQ, WAIT, VALID. All outputs are registered.
- IDLE:
  - If !stall && !flush && !misalign_err && pc_in[1:0]==0: latch pc_in into req_pc and imem_addr, set imem_req=1, go REQ.
  - If pc_in[1:0]!=0 under the same conditions: set misalign_err=1, issue no request, stay IDLE.
  - Only flush clears the sticky misalign_err.
- REQ:
  - imem_req stays 1 with imem_addr held.
  - If flush: imem_req=0, go IDLE (request withdrawn, no response expected).
  - Else if imem_ready: imem_req=0, counter=0, go WAIT.
  - stall does not withdraw a request already issued.
- WAIT:
  - imem_rvalid is only honoured in WAIT; memory responds no earlier than the cycle after acceptance. An rvalid in any other state is ignored.
  - A flush in WAIT sets discard=1.
  - If imem_rvalid && (discard || flush): drop the data, discard=0, go IDLE.
  - Else if imem_rvalid: instr_out=imem_rdata, instr_pc_out=req_pc, instr_valid=1, go VALID.
  - Else counter+1. When the counter reaches TIMEOUT_CYCLES-1 without rvalid: fetch_err=1, discard=0, go IDLE.
- VALID:
  - flush has priority: instr_valid=0, instr_out=NOP_INSTR, go IDLE, no pc_advance.
  - Else if stall: hold instr_out, instr_pc_out and instr_valid unchanged.
  - Else: pc_advance=1 for one cycle, instr_valid=0, go IDLE.
- Latency: with imem_ready=1 at the first REQ cycle and rvalid at the first WAIT cycle:
  - pc_in sampled at edge 0; imem_req high in cycle 1; instr_valid high in cycle 3; pc_advance in cycle 4.
  - Minimum fetch period is 4 cycles.
- fetch_err is sticky until rst and does not block further fetches.
- fetch_busy = (state != IDLE).

Test Plan:
1. Reset, then pc_in=0x00000000 with ready=1 and rvalid one cycle after accept, rdata=0x00500093 -> instr_valid=1 with instr_out=0x00500093 and instr_pc_out=0 in cycle 3; pc_advance pulse in cycle 4; no error flags.
2. stall=1 for 5 cycles while in VALID, with instr 0x00002083 @ 0x8 -> instr_out, instr_pc_out and instr_valid held all 5 cycles; pc_advance only in the cycle after stall falls.
3. flush in WAIT, then rvalid with rdata=0xDEADBEEF -> data discarded, instr_valid stays 0, instr_out remains NOP_INSTR; the next fetch of pc_in=0x40 completes normally.
4. imem_ready held low for 3 cycles at imem_addr=0x10 -> imem_req=1 and imem_addr=0x10 stable throughout; flush during the hold -> imem_req=0 the next cycle and state returns to IDLE.
5. rvalid never arrives with TIMEOUT_CYCLES=16 -> fetch_err=1 after 16 cycles in WAIT, fetch_busy falls, and fetch_err stays 1 across later successful fetches until rst.
6. pc_in=0x00000006 -> misalign_err=1, imem_req never asserted; flush with pc_in=0x8 -> misalign_err clears and the fetch proceeds. Separately, rst pulsed while in WAIT -> all outputs return to reset values.
